c432_key_ctrl: RTL and testbench

Key-load controller for the key-locked c432 netlist. It accepts an obfuscation key as a serial frame with a trailing check nibble, validates it, and drives the key inputs `s_0`..`s_11` of the locked c432 netlist only after validation passes. It counts failed loads and enters a sticky lockout after a configurable number of failures. It sits between the on-chip key source (fuse/NVM reader or test port) and the locked c432 netlist.

---
 rtl/c432_lock_pkg.sv | 11 +
 rtl/key_chk_fold.sv | 14 +
 rtl/c432_key_ctrl.sv | 87 ++++++++
 tb/tb_c432_key_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/c432_lock_pkg.sv
// c432_lock_pkg: shared state encoding, default widths and key check fold
package c432_lock_pkg;
    typedef enum logic [2:0] {IDLE, SHIFT, CHECK, ACTIVE, LOCKOUT} state_t;
    localparam int DEF_KEY_W = 12;
    localparam int DEF_CHK_W = 4;
    function automatic logic [DEF_CHK_W-1:0] chk_fold(input logic [DEF_KEY_W-1:0] k);
        chk_fold = '0;
        for (int i = 0; i < DEF_KEY_W / DEF_CHK_W; i++)
            chk_fold ^= k[i*DEF_CHK_W +: DEF_CHK_W];
    endfunction
endpackage

// File: rtl/key_chk_fold.sv
// key_chk_fold: XOR-fold of a key into CHK_W check bits
module key_chk_fold #(
    parameter int KEY_W = 12,
    parameter int CHK_W = 4
) (
    input  logic [KEY_W-1:0] key,
    output logic [CHK_W-1:0] chk
);
    always_comb begin
        chk = '0;
        for (int i = 0; i < KEY_W / CHK_W; i++)
            chk ^= key[i*CHK_W +: CHK_W];
    end
endmodule

// File: rtl/c432_key_ctrl.sv
// c432_key_ctrl: serial key loader with check nibble, failure count and sticky lockout
module c432_key_ctrl
    import c432_lock_pkg::*;
#(
    parameter int KEY_W    = DEF_KEY_W,
    parameter int CHK_W    = DEF_CHK_W,
    parameter int MAX_FAIL = 3
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          bit_valid,
    input  logic                          bit_sof,
    input  logic                          bit_data,
    output logic                          bit_ready,
    input  logic                          key_clr,
    output logic [KEY_W-1:0]              key_o,
    output logic                          key_valid,
    output logic                          busy,
    output logic                          load_err,
    output logic                          locked,
    output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt
);
    localparam int FRAME_W = KEY_W + CHK_W;
    localparam int CW = $clog2(FRAME_W);
    localparam int FW = $clog2(MAX_FAIL + 1);
    state_t state, nxt;
    logic [CW-1:0] cnt;
    logic [FRAME_W-1:0] shadow;
    logic [CHK_W-1:0] chk;
    logic [FW-1:0] fail_nxt;
    logic beat, sof, clr, match, checking;
    key_chk_fold #(.KEY_W(KEY_W), .CHK_W(CHK_W)) u_fold (.key(shadow[KEY_W-1:0]), .chk(chk));
    assign bit_ready = rst_n && (state == IDLE || state == SHIFT || state == ACTIVE);
    assign beat      = bit_valid && bit_ready;
    assign sof       = beat && bit_sof;
    assign clr       = key_clr && state != LOCKOUT;
    assign match     = chk == shadow[FRAME_W-1:KEY_W];
    assign checking  = state == CHECK && !clr;
    assign fail_nxt  = fail_cnt == FW'(MAX_FAIL) ? fail_cnt : fail_cnt + 1'b1;
    always_comb begin
        nxt = state;
        if (clr)
            nxt = IDLE;
        else
            case (state)
                IDLE, ACTIVE: nxt = sof ? SHIFT : state;
                SHIFT:   nxt = beat && !bit_sof && cnt == CW'(FRAME_W-1) ? CHECK : SHIFT;
                CHECK:   nxt = match ? ACTIVE : fail_nxt == FW'(MAX_FAIL) ? LOCKOUT : IDLE;
                LOCKOUT: nxt = LOCKOUT;
                default: nxt = IDLE;
            endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            shadow    <= '0;
            key_o     <= '0;
            key_valid <= 1'b0;
            busy      <= 1'b0;
            load_err  <= 1'b0;
            locked    <= 1'b0;
            fail_cnt  <= '0;
        end else begin
            state     <= nxt;
            key_valid <= nxt == ACTIVE;
            busy      <= nxt == SHIFT || nxt == CHECK;
            locked    <= nxt == LOCKOUT;
            load_err  <= checking && !match;
            if (checking && !match)
                fail_cnt <= fail_nxt;
            if (checking && match)
                key_o <= shadow[KEY_W-1:0];
            else if (nxt != ACTIVE)
                key_o <= '0;
            if (clr || state == CHECK)
                shadow <= '0;
            else if (sof) begin
                shadow <= FRAME_W'(bit_data);
                cnt    <= CW'(1);
            end else if (beat && state == SHIFT) begin
                shadow[cnt] <= bit_data;
                cnt         <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_c432_key_ctrl.sv
// tb_c432_key_ctrl: directed and randomized frames against a transaction-level key loader model
module tb_c432_key_ctrl;
    logic clk = 1'b0;
    logic rst_n, bit_valid, bit_sof, bit_data, bit_ready, key_clr;
    logic [11:0] key_o;
    logic key_valid, busy, load_err, locked;
    logic [1:0] fail_cnt;
    int checks = 0;
    int errors = 0;
    int m_fail = 0;
    logic [11:0] m_key = '0;
    logic m_valid = 1'b0;
    c432_key_ctrl dut (
        .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_sof(bit_sof),
        .bit_data(bit_data), .bit_ready(bit_ready), .key_clr(key_clr), .key_o(key_o),
        .key_valid(key_valid), .busy(busy), .load_err(load_err), .locked(locked),
        .fail_cnt(fail_cnt)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    function automatic logic [3:0] fold(input logic [11:0] k);
        int s = 0;
        for (int i = 0; i < 3; i++)
            s = s ^ ((int'(k) >> (4 * i)) % 16);
        return 4'(s);
    endfunction
    task automatic put_beat(input logic b, input logic s);
        int n = 0;
        bit_valid = 1'b1;
        bit_sof = s;
        bit_data = b;
        while (!bit_ready && n < 100) begin
            tick();
            n++;
        end
        if (n == 100)
            chk("ready_timeout", 32'(bit_ready), 32'd1);
        tick();
        bit_valid = 1'b0;
        bit_sof = 1'b0;
    endtask
    task automatic send_frame(input logic [11:0] k, input logic [3:0] c, input bit gaps);
        logic [15:0] f;
        bit good;
        f = {c, k};
        for (int i = 0; i < 16; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                bit_valid = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
            end
            put_beat(f[i], i == 0);
        end
        chk("busy_in_check", 32'(busy), 32'd1);
        chk("no_key_in_check", 32'(key_valid), 32'd0);
        tick();
        good = fold(k) == c;
        if (good) begin
            m_key = k;
            m_valid = 1'b1;
        end else begin
            m_fail = m_fail < 3 ? m_fail + 1 : 3;
            m_key = '0;
            m_valid = 1'b0;
        end
        chk("key_o", 32'(key_o), 32'(m_key));
        chk("key_valid", 32'(key_valid), 32'(m_valid));
        chk("load_err", 32'(load_err), 32'(!good));
        chk("fail_cnt", 32'(fail_cnt), 32'(m_fail));
        chk("locked", 32'(locked), 32'(m_fail == 3));
        tick();
        chk("load_err_pulse", 32'(load_err), 32'd0);
    endtask
    initial begin
        logic [11:0] k;
        rst_n = 1'b0;
        bit_valid = 1'b0;
        bit_sof = 1'b0;
        bit_data = 1'b0;
        key_clr = 1'b0;
        tick();
        tick();
        chk("rst_ready", 32'(bit_ready), 32'd0);
        chk("rst_key", 32'(key_o), 32'd0);
        chk("rst_fail", 32'(fail_cnt), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_ready", 32'(bit_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_locked", 32'(locked), 32'd0);
        send_frame(12'hA5C, 4'h3, 1'b0);
        put_beat(1'b0, 1'b1);
        chk("reload_key_zero", 32'(key_o), 32'd0);
        chk("reload_valid", 32'(key_valid), 32'd0);
        chk("reload_busy", 32'(busy), 32'd1);
        key_clr = 1'b1;
        put_beat(1'b1, 1'b1);
        key_clr = 1'b0;
        chk("clr_key", 32'(key_o), 32'd0);
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_fail", 32'(fail_cnt), 32'(m_fail));
        m_valid = 1'b0;
        m_key = '0;
        send_frame(12'hA5C, 4'h0, 1'b0);
        chk("bad_back_idle", 32'(bit_ready), 32'd1);
        chk("bad_not_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 7; i++)
            put_beat(1'($urandom_range(0, 1)), i == 0);
        send_frame(12'h123, 4'h0, 1'b0);
        for (int n = 0; n < 4; n++) begin
            k = 12'($urandom);
            send_frame(k, fold(k), 1'b1);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_fail = 0;
        chk("midrst_fail", 32'(fail_cnt), 32'd0);
        chk("midrst_valid", 32'(key_valid), 32'd0);
        for (int n = 0; n < 3; n++) begin
            k = 12'($urandom);
            send_frame(k, fold(k) ^ 4'(1 << n), n == 1);
        end
        chk("lock_ready", 32'(bit_ready), 32'd0);
        bit_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bit_sof = i == 0;
            bit_data = 1'($urandom_range(0, 1));
            key_clr = i == 8;
            tick();
        end
        bit_valid = 1'b0;
        bit_sof = 1'b0;
        key_clr = 1'b0;
        tick();
        chk("lock_sticky", 32'(locked), 32'd1);
        chk("lock_key", 32'(key_o), 32'd0);
        chk("lock_valid", 32'(key_valid), 32'd0);
        chk("lock_fail", 32'(fail_cnt), 32'd3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("unlock_locked", 32'(locked), 32'd0);
        chk("unlock_fail", 32'(fail_cnt), 32'd0);
        chk("unlock_busy", 32'(busy), 32'd0);
        chk("unlock_err", 32'(load_err), 32'd0);
        m_fail = 0;
        send_frame(12'h5A3, fold(12'h5A3), 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
